// File: rtl/div_sing_float_seq.sv
// Sequential single-precision float divider: result = num1 / num2.
// Both significands are truncated to MW bits including the hidden bit. A radix-2 restoring
// divider then produces one quotient bit per cycle over MW+1 steps. Zero operands
// (exponent field 0) are resolved one cycle after accept. Denormals are flushed.
// The mantissa is truncated, not rounded, and the exponent wraps modulo 256.
module div_sing_float_seq #(
  parameter int unsigned MW = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned QW = MW + 1;
  // One code beyond MW is needed so all-ones can mark "all bit steps finished".
  localparam int unsigned CW = $clog2(MW + 2);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [7:0]      e1_q, e1_d;
  logic [7:0]      e2_q, e2_d;
  logic [MW-1:0]   m2_q, m2_d;
  logic [QW-1:0]   rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     result_q, result_d;

  logic [MW-1:0]   m1_in, m2_in;
  logic [QW-1:0]   diff;
  logic            ge;
  logic [8:0]      exp_sum;
  logic [22:0]     man_norm;
  logic            special;
  logic [31:0]     special_val;
  logic            unused_bits;

  // Truncated significands with the hidden bit restored.
  always_comb begin
    m1_in = {1'b1, num1[22 -: MW-1]};
    m2_in = {1'b1, num2[22 -: MW-1]};
  end

  // Datapath: restoring subtract and compare, normalisation, and zero-operand results.
  always_comb begin
    diff     = rem_q - {1'b0, m2_q};
    ge       = rem_q >= {1'b0, m2_q};
    exp_sum  = {1'b0, e1_q} - {1'b0, e2_q} + (quo_q[MW] ? 9'd127 : 9'd126);
    man_norm = quo_q[MW] ? (23'(quo_q[MW-1:0]) << (23 - MW))
                         : (23'(quo_q[MW-2:0]) << (24 - MW));
    special  = (e1_q == 8'h00) || (e2_q == 8'h00);
    if (e1_q == 8'h00 && e2_q == 8'h00) begin
      special_val = 32'h7FC0_0000;
    end else if (e2_q == 8'h00) begin
      special_val = {sign_q, 8'hFF, 23'h0};
    end else begin
      special_val = {sign_q, 31'h0};
    end
  end

  // Bits that are deliberately dropped by truncation or by the wrapping exponent.
  always_comb begin
    unused_bits = ^{num1[23-MW:0], num2[23-MW:0], diff[MW], exp_sum[8]};
  end

  // Next-state logic. Zero operands also pass through StDiv for one cycle so their
  // result appears one edge after accept.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    e1_d     = e1_q;
    e2_d     = e2_q;
    m2_d     = m2_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = num1[31] ^ num2[31];
          e1_d    = num1[30:23];
          e2_d    = num2[30:23];
          m2_d    = m2_in;
          rem_d   = {1'b0, m1_in};
          quo_d   = '0;
          cnt_d   = CW'(MW);
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (special) begin
          result_d = special_val;
          state_d  = StDone;
        end else if (cnt_q == {CW{1'b1}}) begin
          result_d = {sign_q, exp_sum[7:0], man_norm};
          state_d  = StDone;
        end else begin
          // Quotient bits enter at the LSB, so after MW+1 steps bit k lands at index k.
          quo_d = {quo_q[QW-2:0], ge};
          rem_d = ge ? {diff[MW-1:0], 1'b0} : {rem_q[MW-1:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      e1_q     <= '0;
      e2_q     <= '0;
      m2_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      m2_q     <= m2_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    result = result_q;
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
  end

endmodule

// File: tb/tb_div_sing_float_seq.sv
// Scoreboard bench for div_sing_float_seq. The expected result and done cycle are queued
// at each accepted start and then checked when done pulses.
module tb_div_sing_float_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_sing_float_seq #(.MW(14)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num1   (num1),
    .num2   (num2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check each done pulse against the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
        chk("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Issue one start pulse while idle. After edge N, done is expected when cyc == N + lat.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat);
    @(negedge clk);
    num1  = a;
    num2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{exp_res, cyc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy == 1'b0) break;
    end
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bc;
    int d0;

    rst   = 1'b1;
    start = 1'b0;
    num1  = '0;
    num2  = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // 6.0 / 2.0: measure how long busy stays high (16 DIV cycles + 1 DONE cycle).
    d0 = done_cnt;
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 16);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      bc++;
      @(negedge clk);
    end
    chk("busy_len", 32'(bc), 32'd17);
    wait_idle();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);

    // Q[14]=0 normalisation path, sign XOR, unity, and both-negative cases.
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_A800, 16);
    wait_idle();
    run_op(32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, 16);
    wait_idle();
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 16);
    wait_idle();
    run_op(32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000, 16);
    wait_idle();

    // Zero operands resolve one edge after accept.
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1);
    wait_idle();
    run_op(32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 1);
    wait_idle();
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);
    wait_idle();
    run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);
    wait_idle();
    run_op(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1);
    wait_idle();

    // A start while busy is ignored, and operand changes mid-divide have no effect.
    d0 = done_cnt;
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 16);
    repeat (4) @(negedge clk);
    num1  = 32'h3F80_0000;
    num2  = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_reject_pulses", 32'(done_cnt - d0), 32'd1);
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_A800, 16);
    wait_idle();

    // Reset in the middle of a divide discards it.
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 16);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'h0);
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 16);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
